// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared token layout, end marker and packer state encoding
package lz77_pkg;

    localparam int TOKEN_W = 15;
    localparam logic [7:0] END_CHAR = 8'h24;

    localparam int OFF_MSB = 14;
    localparam int LEN_MSB = 10;
    localparam int CHR_MSB = 7;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/lz77_code_packer_if.sv
// rtl/lz77_code_packer_if.sv - encoder token input and packed word output bundle
interface lz77_code_packer_if #(
    parameter int WORD_W = 32
);
    logic              valid;
    logic              encode;
    logic [3:0]        offset;
    logic [2:0]        match_len;
    logic [7:0]        chardata;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              done;
    logic              overflow;

    modport master (
        output valid, encode, offset, match_len, chardata, out_ready,
        input  out_data, out_valid, out_last, done, overflow
    );

    modport slave (
        input  valid, encode, offset, match_len, chardata, out_ready,
        output out_data, out_valid, out_last, done, overflow
    );
endinterface

// File: rtl/lz77_token_fifo.sv
// rtl/lz77_token_fifo.sv - small synchronous FIFO; a push into a full FIFO lands only with a same-cycle pop
module lz77_token_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/lz77_code_packer.sv
// rtl/lz77_code_packer.sv - packs 15-bit LZ77 tokens MSB-first into words, flushing on the end token
module lz77_code_packer #(
    parameter int         WORD_W     = 32,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] END_CHAR   = lz77_pkg::END_CHAR
) (
    input logic               clk,
    input logic               reset,
    lz77_code_packer_if.slave bus
);
    import lz77_pkg::*;

    localparam int ACC_W = WORD_W + TOKEN_W - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] TOP_GAP  = CNT_W'(ACC_W - TOKEN_W);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [TOKEN_W-1:0] token_in;
    logic [TOKEN_W-1:0] head;
    logic               push, pop, fifo_full, fifo_empty;
    logic               word_full, overflow_q;

    assign push = bus.valid && bus.encode;
    assign token_in[OFF_MSB:LEN_MSB+1] = bus.offset;
    assign token_in[LEN_MSB:CHR_MSB+1] = bus.match_len;
    assign token_in[CHR_MSB:0]         = bus.chardata;

    lz77_token_fifo #(.WIDTH(TOKEN_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (token_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outputs are decoded from registered state, so they cannot change while a word is stalled.
    assign word_full     = (cnt >= WORD_CNT);
    assign bus.out_valid = ((state == PACK) && word_full) || (state == FLUSH);
    assign bus.out_last  = (state == FLUSH) && (cnt <= WORD_CNT);
    assign bus.out_data  = bus.out_valid ? acc[ACC_W-1 -: WORD_W] : '0;
    assign bus.done      = (state == DONE);
    assign bus.overflow  = overflow_q;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = PACK;
            end
            PACK: begin
                if (word_full) begin
                    if (bus.out_ready) begin
                        acc_nxt = acc << WORD_W;
                        cnt_nxt = cnt - WORD_CNT;
                    end
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    acc_nxt = acc | (ACC_W'(head) << (TOP_GAP - cnt));
                    cnt_nxt = cnt + CNT_W'(TOKEN_W);
                    if (head[CHR_MSB:0] == END_CHAR) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Tokens of the next stream wait in the FIFO until this one is fully drained.
                if (bus.out_ready) begin
                    if (bus.out_last) begin
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        acc_nxt = acc << WORD_W;
                        cnt_nxt = cnt - WORD_CNT;
                    end
                end
            end
            DONE: begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            if (push && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lz77_code_packer.sv
// tb/tb_lz77_code_packer.sv - directed and randomized self-checking bench for lz77_code_packer
module tb_lz77_code_packer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lz77_code_packer_if #(.WORD_W(32)) bus ();
    lz77_code_packer_if #(.WORD_W(30)) fb ();

    lz77_code_packer #(.WORD_W(32), .FIFO_DEPTH(4), .END_CHAR(8'h24)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    lz77_code_packer #(.WORD_W(30), .FIFO_DEPTH(4), .END_CHAR(8'h24)) u_fit (
        .clk(clk), .reset(reset), .bus(fb));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, acc_cyc = 0, valid_seen = 0;
    bit rnd_ready = 0;
    logic [31:0] got_w[$];
    logic        got_l[$];
    logic [31:0] exp_w[$];
    logic        exp_l[$];
    logic [14:0] stream[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_w.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
            acc_cyc = cyc;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.out_valid) valid_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_tok(input logic [14:0] t, input int gap);
        bus.valid  = 1'b1;
        bus.encode = 1'b1;
        {bus.offset, bus.match_len, bus.chardata} = t;
        stream.push_back(t);
        step();
        bus.valid = 1'b0;
        repeat (gap - 1) step();
    endtask

    function automatic logic [14:0] rand_tok(input bit is_end);
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        if (is_end) c = 8'h24;
        else if (c == 8'h24) c = 8'h25;
        return {4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), c};
    endfunction

    task automatic start_stream();
        stream.delete();
        got_w.delete();
        got_l.delete();
        done_cnt = 0;
    endtask

    // Reference: concatenate token bits MSB-first, zero-pad to whole words, cut into words.
    task automatic build_exp(input int ww);
        bit          bq[$];
        logic [31:0] v;
        exp_w.delete();
        exp_l.delete();
        foreach (stream[i]) for (int b = 14; b >= 0; b--) bq.push_back(stream[i][b]);
        while (bq.size() % ww != 0) bq.push_back(1'b0);
        for (int w = 0; w * ww < bq.size(); w++) begin
            v = '0;
            for (int b = 0; b < ww; b++) v = {v[30:0], bq[w * ww + b]};
            exp_w.push_back(v);
            exp_l.push_back((w + 1) * ww == bq.size());
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        repeat (3) step();
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_done_timing"}, done_cyc, acc_cyc + 1);
    endtask

    task automatic check_stream(input string tag);
        build_exp(32);
        chk({tag, "_nwords"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            chk({tag, "_word"}, got_w[i], exp_w[i]);
            chk({tag, "_last"}, got_l[i], exp_l[i]);
        end
    endtask

    task automatic basic_stream(input string tag);
        push_tok(15'h0001, 2);
        push_tok({4'd1, 3'd2, 8'h05}, 2);
        push_tok(15'h0024, 2);
    endtask

    initial begin
        int n;
        int kept;
        bus.valid = 0; bus.encode = 0; bus.offset = 0; bus.match_len = 0;
        bus.chardata = 0; bus.out_ready = 0;
        fb.valid = 0; fb.encode = 0; fb.offset = 0; fb.match_len = 0;
        fb.chardata = 0; fb.out_ready = 0;
        reset = 1'b0;
        repeat (3) step();
        chk("rst_data", bus.out_data, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overflow", bus.overflow, 0);
        reset = 1'b1;
        step();

        bus.out_ready = 1'b1;
        start_stream();
        basic_stream("basic");
        wait_done("basic", 60);
        check_stream("basic");
        chk("basic_w0", got_w.size() > 0 ? got_w[0] : 32'hx, 32'h00022814);
        chk("basic_w1", got_w.size() > 1 ? got_w[1] : 32'hx, 32'h01200000);

        bus.out_ready = 1'b0;
        start_stream();
        basic_stream("bp");
        n = 0;
        while (!bus.out_valid && n < 20) begin step(); n++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_data", bus.out_data, 32'h00022814);
            chk("bp_hold_valid", bus.out_valid, 1);
            step();
        end
        chk("bp_overflow", bus.overflow, 0);
        bus.out_ready = 1'b1;
        wait_done("bp", 60);
        check_stream("bp");

        bus.out_ready = 1'b0;
        start_stream();
        kept = (32 + 14) / 15 + 4;
        for (int i = 1; i <= 9; i++) begin
            push_tok(rand_tok(1'b0), 1);
            chk("ovf_flag", bus.overflow, (i > kept));
        end
        stream = stream[0:kept-1];
        bus.out_ready = 1'b1;
        repeat (10) step();
        push_tok(rand_tok(1'b1), 2);
        wait_done("ovf", 100);
        check_stream("ovf");
        chk("ovf_sticky", bus.overflow, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("ovf_cleared", bus.overflow, 0);

        stream.delete();
        stream.push_back(15'h0001);
        stream.push_back(15'h0024);
        build_exp(30);
        fb.encode = 1'b1;
        fb.valid = 1'b1;
        {fb.offset, fb.match_len, fb.chardata} = 15'h0001;
        step();
        fb.valid = 1'b0;
        step();
        fb.valid = 1'b1;
        {fb.offset, fb.match_len, fb.chardata} = 15'h0024;
        step();
        fb.valid = 1'b0;
        n = 0;
        while (!fb.out_valid && n < 20) begin step(); n++; end
        chk("fit_data", fb.out_data, exp_w[0]);
        chk("fit_data_const", fb.out_data, 32'h00008024);
        chk("fit_last", fb.out_last, 1);
        fb.out_ready = 1'b1;
        step();
        chk("fit_done", fb.done, 1);
        chk("fit_no_pad", fb.out_valid, 0);
        fb.out_ready = 1'b0;

        bus.out_ready = 1'b0;
        start_stream();
        push_tok(rand_tok(1'b1), 2);
        n = 0;
        while (!(bus.out_valid && bus.out_last) && n < 20) begin step(); n++; end
        chk("mf_in_flush", bus.out_valid && bus.out_last, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mf_data", bus.out_data, 0);
        chk("mf_valid", bus.out_valid, 0);
        chk("mf_last", bus.out_last, 0);
        chk("mf_done", bus.done, 0);
        chk("mf_overflow", bus.overflow, 0);
        repeat (5) step();
        chk("mf_fifo_empty", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        start_stream();
        basic_stream("mf");
        wait_done("mf", 60);
        check_stream("mf");

        valid_seen = 0;
        bus.valid = 1'b1;
        bus.encode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            {bus.offset, bus.match_len, bus.chardata} = rand_tok(i % 3 == 0);
            step();
        end
        bus.valid = 1'b0;
        repeat (10) step();
        chk("dec_no_output", valid_seen, 0);
        chk("dec_overflow", bus.overflow, 0);

        rnd_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            start_stream();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n - 1; k++) push_tok(rand_tok(1'b0), $urandom_range(3, 4));
            push_tok(rand_tok(1'b1), 3);
            wait_done("rnd", 300);
            check_stream("rnd");
        end
        rnd_ready = 1'b0;
        chk("rnd_overflow", bus.overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
